// File: rtl/div_pkg.sv
// Shared types and constants for the div_param iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Counter width for an N-cycle iteration; counter runs 0..N-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Fill bit for the divide-by-zero quotient (all ones at any width).
  localparam logic DIV_ZERO_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial subtract, restore.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N:0]   i_rem,
  input  logic         i_bit,
  input  logic [N-1:0] i_div,
  output logic [N:0]   o_rem,
  output logic         o_q
);

  logic [N:0] w_shift;
  logic [N:0] w_diff;
  logic       w_unused_msb;

  // The restored remainder is always below the divisor, so its top bit is never needed.
  assign w_unused_msb = i_rem[N];

  always_comb begin
    w_shift = {i_rem[N-1:0], i_bit};
    w_diff  = w_shift - {1'b0, i_div};
    o_q     = (w_shift >= {1'b0, i_div});
    o_rem   = o_q ? w_diff : w_shift;
  end

endmodule

// File: rtl/div_param.sv
// Parametrised radix-2 restoring divider with valid/ready handshakes.
// Define DIV_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module div_param
  import div_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         in_error
);

  localparam int unsigned CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  div_state_t       r_state;
  div_state_t       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_dvd;
  logic [N-1:0]     r_div;
  logic [N-1:0]     r_x;
  logic [N-1:0]     r_quo;
  logic [N:0]       r_rem;
  logic             r_div_zero;
  logic [N:0]       w_rem_next;
  logic             w_qbit;
  logic [N-1:0]     w_dvd_in;
  logic [N-1:0]     w_div_in;
  logic [N-1:0]     w_q_fix;
  logic [N-1:0]     w_r_fix;

`ifdef DIV_SIGNED_EN
  logic w_xneg;
  logic w_yneg;
  logic r_qneg;
  logic r_rneg;

  // Magnitudes as N-bit unsigned: -2^(N-1) maps to 2^(N-1), which makes overflow fall out naturally.
  assign w_xneg   = is_signed & X[N-1];
  assign w_yneg   = is_signed & Y[N-1];
  assign w_dvd_in = w_xneg ? -X : X;
  assign w_div_in = w_yneg ? -Y : Y;
  assign w_q_fix  = r_qneg ? -r_quo : r_quo;
  assign w_r_fix  = r_rneg ? -r_rem[N-1:0] : r_rem[N-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_qneg <= w_xneg ^ w_yneg;
      r_rneg <= w_xneg;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = is_signed;
  assign w_dvd_in        = X;
  assign w_div_in        = Y;
  assign w_q_fix         = r_quo;
  assign w_r_fix         = r_rem[N-1:0];
`endif

  div_step #(.N(N)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[N-1]),
    .i_div (r_div),
    .o_rem (w_rem_next),
    .o_q   (w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_next = (Y == '0) ? FIX : CALC;
      CALC:    if (r_cnt == CNT_LAST) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_div      <= '0;
      r_x        <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
      Q          <= '0;
      R          <= '0;
      in_error   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd      <= w_dvd_in;
            r_div      <= w_div_in;
            r_x        <= X;
            r_quo      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_div_zero <= (Y == '0);
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[N-2:0], w_qbit};
          r_dvd <= {r_dvd[N-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          if (r_div_zero) begin
            Q        <= {N{DIV_ZERO_FILL}};
            R        <= r_x;
            in_error <= 1'b1;
          end else begin
            Q        <= w_q_fix;
            R        <= w_r_fix;
            in_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_param.sv
// Directed and random checks for div_param (N = 32), honouring DIV_SIGNED_EN if defined.
module tb_div_param;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         in_error;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_param #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .in_error  (in_error)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operation and count edges from the accept edge until out_valid.
  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic s, output int lat);
    @(negedge clk);
    for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
    X = x; Y = y; is_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    X = $urandom; Y = $urandom; is_signed = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                    input logic [N-1:0] eq, input logic [N-1:0] er, input logic ee, input int elat);
    int lat;
    issue(x, y, s, lat);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".Q"}, Q, eq);
    chk({tag, ".R"}, R, er);
    chk({tag, ".err"}, in_error, ee);
    drain();
    chk({tag, ".rdy"}, in_ready, 1'b1);
  endtask

  function automatic void model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                                output logic [N-1:0] q, output logic [N-1:0] r, output logic e);
    logic ss;
    ss = s;
`ifndef DIV_SIGNED_EN
    ss = 1'b0;
`endif
    if (y == '0) begin
      q = '1; r = x; e = 1'b1;
    end else begin
      e = 1'b0;
      if (ss && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = '0;
      end else if (ss) begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
      end else begin
        q = x / y;
        r = x % y;
      end
    end
  endfunction

  initial begin
    int lat;
    logic [N-1:0] rx, ry, eq, er;
    logic rs, ee;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    X = '0; Y = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rdy", in_ready, 1'b1);
    chk("rst.ov", out_valid, 1'b0);
    chk("rst.Q", Q, '0);
    chk("rst.R", R, '0);
    chk("rst.err", in_error, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    op("u100d7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
`ifdef DIV_SIGNED_EN
    op("sm7d2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    op("s7dm2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    op("sm7dm2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, 33);
    op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
`else
    op("sm7d2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, 33);
    op("s7dm2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 1'b0, 33);
    op("sm7dm2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'hFFFF_FFF9, 1'b0, 33);
    op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 33);
`endif
    op("uF9d2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 33);
    op("u5d0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    op("s5d0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    op("sm5d0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
    op("uMaxd1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    op("u6d7", 32'd6, 32'd7, 1'b0, 32'd0, 32'd6, 1'b0, 33);

    // Backpressure: result held in DONE, new request ignored until after the drain edge.
    issue(32'd1000, 32'd3, 1'b0, lat);
    chk("bp.lat", lat, 33);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1; X = 32'd50; Y = 32'd5; is_signed = 1'b0;
      chk("bp.ov", out_valid, 1'b1);
      chk("bp.Q", Q, 32'd333);
      chk("bp.R", R, 32'd1);
      chk("bp.rdy", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.drain.ov", out_valid, 1'b0);
    chk("bp.drain.rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.acc.rdy", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2.lat", lat, 33);
    chk("bp2.Q", Q, 32'd10);
    chk("bp2.R", R, 32'd0);
    drain();

    // Asynchronous abort mid-CALC.
    @(negedge clk);
    X = 32'd1000; Y = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.rdy", in_ready, 1'b1);
    chk("arst.ov", out_valid, 1'b0);
    chk("arst.Q", Q, '0);
    chk("arst.R", R, '0);
    chk("arst.err", in_error, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("arst.idle.ov", out_valid, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      rx = $urandom;
      ry = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        rx = 32'h8000_0000; ry = 32'hFFFF_FFFF;
      end
      rs = 1'($urandom);
      model(rx, ry, rs, eq, er, ee);
      issue(rx, ry, rs, lat);
      chk("rnd.Q", Q, eq);
      chk("rnd.R", R, er);
      chk("rnd.err", in_error, ee);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_param.md
# div_param

Parametrised iterative radix-2 restoring divider, the successor to the fixed 32-bit divider. It computes quotient and remainder of an N-bit dividend by an N-bit divisor, one quotient bit per clock. It adds a per-operation signed/unsigned mode, valid/ready handshakes on both input and output, and defined results for divide-by-zero and signed overflow. It sits in the execute stage as a multi-cycle functional unit behind the ALU.

## Interface

Parameters:
- N, 32, operand and result width (≥ 2)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands X, Y, is_signed valid
- in_ready  out  1  divider can accept; high only in IDLE
- X  in  N  dividend
- Y  in  N  divisor
- is_signed  in  1  1 = two's-complement operation, 0 = unsigned
- out_valid  out  1  Q, R, in_error valid
- out_ready  in  1  consumer takes the result
- Q  out  N  quotient
- R  out  N  remainder
- in_error  out  1  divisor was zero for this result

## Operation

- Accept happens on a rising edge with in_valid && in_ready. X, Y, and is_signed are latched.
- States:
  - IDLE: accept → CALC, or → FIX if Y == 0.
  - CALC: N cycles, then → FIX.
  - FIX: always → DONE.
  - DONE: out_ready → IDLE.
- CALC:
  - Uses magnitudes |X| and |Y| as N-bit unsigned when signed, raw values otherwise.
  - Shift-subtract-restore per cycle; the counter runs 0..N-1.
  - Partial remainder is N+1 bits wide.
- FIX, signed:
  - Quotient is negated when sign(X) ≠ sign(Y), so it truncates toward zero.
  - Remainder takes the sign of X.
  - Results match Verilog `/` and `%`.
- Divide by zero: Q = all ones, R = X unchanged, in_error = 1, in either mode.
- Signed overflow, X = -2^(N-1) and Y = -1: Q = -2^(N-1), R = 0, in_error = 0. This falls out of the magnitude path and needs no special case.
- in_error = 0 for every non-zero divisor.
- Q, R, and in_error are registered. They stay stable while out_valid = 1 and keep their values after drain until the next FIX.

## Timing

- Reset values: state = IDLE, in_ready = 1, out_valid = 0, Q = 0, R = 0, in_error = 0. The counter and datapath registers are also cleared.
- Normal latency: accept edge E0, CALC on E1..EN, FIX on EN+1. out_valid rises after edge EN+1, i.e. N+1 cycles (33 for N = 32).
- Divide-by-zero latency: out_valid rises after E1.
- out_valid holds until an edge with out_ready = 1. It falls after that edge and the state returns to IDLE.
- in_ready is low from the accept edge until return to IDLE. There is no overlap and no accept in the drain cycle.
- Minimum issue interval is N+3 cycles when out_ready is held high.
- in_valid while in_ready = 0 is ignored; no queueing.
- Changes on X, Y, or is_signed after accept have no effect.
- rst asserted mid-CALC or in DONE aborts immediately to reset values. The partial result is discarded.

## Configuration

- DIV_SIGNED_EN:
  - Defined: is_signed is honoured, and the magnitude, negate, and sign-fix logic is present.
  - Undefined: the port stays, but is_signed is ignored and every operation is unsigned. FIX only forces the divide-by-zero values. Latency is unchanged.

## Structure

- Package div_pkg holds:
  - the state enum (IDLE, CALC, FIX, DONE);
  - the counter width localparam, $clog2(N);
  - the divide-by-zero quotient constant (all ones).
- Sub-module div_step: one combinational restoring step. Inputs are the partial remainder (N+1), the dividend bit, and the divisor (N). Outputs are the next partial remainder and the quotient bit. It is instantiated once and used iteratively.

## Test plan

- Unsigned 100 / 7, N = 32 → Q = 14, R = 2, in_error = 0; out_valid rises exactly 33 cycles after accept.
- Signed -7 / 2 → Q = 0xFFFFFFFD, R = 0xFFFFFFFF. Unsigned 0xFFFFFFF9 / 2 → Q = 0x7FFFFFFC, R = 1.
- 5 / 0 (either mode) → Q = 0xFFFFFFFF, R = 5, in_error = 1; out_valid one cycle after accept. Signed 0x80000000 / 0xFFFFFFFF → Q = 0x80000000, R = 0, in_error = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → out_valid, Q, and R stay stable and in_ready = 0. One cycle after out_ready = 1 → in_ready = 1, and a new op is accepted.
- Assert rst 10 cycles into CALC → all outputs go to reset values asynchronously. After release, 1000 random signed and unsigned ops match `/` and `%` with 0 errors.
